// File: rtl/mem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_line_responder
// Brief    : 128-bit line backing store answering cache miss/fill requests
//            after a fixed LATENCY, with a level ready_mem handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mem_line_responder #(
    parameter int LATENCY = 5,
    parameter int IDX_W   = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         read_Mem,
    input  logic         write_Mem,
    input  logic [31:0]  Addr_Mem,
    input  logic [127:0] Data_Mem_write,
    output logic [127:0] Data_Mem_read,
    output logic         ready_mem
);

    localparam int DEPTH = 1 << IDX_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             op_wr_q, op_wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [127:0]     wdata_q, wdata_d;
    logic [127:0]     rdata_q, rdata_d;
    logic [127:0]     mem_q [DEPTH];

    logic req;
    logic accept;
    logic commit;
    logic unused_addr_bits;

    assign req              = read_Mem | write_Mem;
    assign accept           = (state_q == S_IDLE) && req;
    // Commit on the edge leaving BUSY so data/array are valid as ready_mem rises.
    assign commit           = (state_q == S_BUSY) && (cnt_q == 8'd0);
    assign unused_addr_bits = ^Addr_Mem;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array contents survive reset; a reset during BUSY suppresses the commit.
    always_ff @(posedge clk) begin
        if (!reset && commit && op_wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req)          state_d = S_BUSY;
            S_BUSY:    if (cnt_q == 8'd0) state_d = S_DONE;
            S_DONE:                      state_d = S_RELEASE;
            S_RELEASE: if (!req)         state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (accept) begin
            cnt_d   = 8'(LATENCY - 1);
            op_wr_d = write_Mem;
            idx_d   = Addr_Mem[4 +: IDX_W];
            wdata_d = Data_Mem_write;
        end else if ((state_q == S_BUSY) && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
        if (commit && !op_wr_q) begin
            rdata_d = mem_q[idx_q];
        end
    end

    // Output logic
    always_comb begin
        ready_mem     = (state_q != S_BUSY);
        Data_Mem_read = rdata_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_line_responder
// Brief    : Directed vector bench for mem_line_responder (LATENCY 5 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_line_responder;

    logic         clk;
    logic         reset;
    logic         rd    [2];
    logic         wr    [2];
    logic [31:0]  addr  [2];
    logic [127:0] wdata [2];
    logic [127:0] rdata [2];
    logic         ready [2];

    int tests;
    int fails;

    mem_line_responder #(.LATENCY(5), .IDX_W(10)) dut0 (
        .clk(clk), .reset(reset),
        .read_Mem(rd[0]), .write_Mem(wr[0]), .Addr_Mem(addr[0]),
        .Data_Mem_write(wdata[0]), .Data_Mem_read(rdata[0]), .ready_mem(ready[0])
    );

    mem_line_responder #(.LATENCY(1), .IDX_W(4)) dut1 (
        .clk(clk), .reset(reset),
        .read_Mem(rd[1]), .write_Mem(wr[1]), .Addr_Mem(addr[1]),
        .Data_Mem_write(wdata[1]), .Data_Mem_read(rdata[1]), .ready_mem(ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           sel;
        logic         r;
        logic         w;
        logic [31:0]  a;
        logic [127:0] d;
        logic [127:0] exp_rd;
        int           exp_lows;
    } vec_t;

    localparam logic [127:0] C_PAT = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_0F0F;

    vec_t vecs [12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Raise a request, count busy cycles, capture read data as ready returns, drop request.
    task automatic access(input int sel, input logic r, input logic w, input logic [31:0] a,
                          input logic [127:0] d, output int lows, output logic [127:0] got,
                          output bit timeout);
        bit done;
        done    = 1'b0;
        lows    = 0;
        got     = '0;
        @(negedge clk);
        rd[sel] = r; wr[sel] = w; addr[sel] = a; wdata[sel] = d;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (ready[sel] == 1'b0) lows++;
            else if (lows > 0) begin
                got  = rdata[sel];
                done = 1'b1;
            end
        end
        timeout = !done;
        rd[sel] = 1'b0; wr[sel] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int           lows;
        logic [127:0] got;
        bit           to;

        tests = 0;
        fails = 0;
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
        end

        vecs[0]  = '{0, 1'b0, 1'b1, 32'h0000_0040, C_PAT,        128'h0,  5};
        vecs[1]  = '{0, 1'b1, 1'b0, 32'h0000_0040, 128'h0,       C_PAT,   5};
        vecs[2]  = '{0, 1'b0, 1'b1, 32'h0000_0100, 128'h5,       C_PAT,   5};
        vecs[3]  = '{0, 1'b1, 1'b1, 32'h0000_0080, 128'h1,       C_PAT,   5};
        vecs[4]  = '{0, 1'b1, 1'b0, 32'h0000_0080, 128'h0,       128'h1,  5};
        vecs[5]  = '{0, 1'b0, 1'b1, 32'h0000_0010, 128'hA,       128'h1,  5};
        vecs[6]  = '{0, 1'b1, 1'b0, 32'h0000_4010, 128'h0,       128'hA,  5};
        vecs[7]  = '{0, 1'b0, 1'b1, 32'h0000_005F, 128'h1234_5678, 128'hA, 5};
        vecs[8]  = '{0, 1'b1, 1'b0, 32'hFFFF_C050, 128'h0,       128'h1234_5678, 5};
        vecs[9]  = '{1, 1'b0, 1'b1, 32'h0000_0030, 128'h77,      128'h0,  1};
        vecs[10] = '{1, 1'b1, 1'b0, 32'h0000_0030, 128'h0,       128'h77, 1};
        vecs[11] = '{1, 1'b1, 1'b0, 32'h0000_0130, 128'h0,       128'h77, 1};

        // Reset state and quiet idle
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready0", 128'(ready[0]), 128'h1);
        check("reset_rdata0", rdata[0], 128'h0);
        check("reset_ready1", 128'(ready[1]), 128'h1);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (!ready[0]) lows++;
        end
        check("idle_no_busy", 128'(lows), 128'h0);

        // Table-driven accesses
        foreach (vecs[i]) begin
            access(vecs[i].sel, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, lows, got, to);
            check($sformatf("vec%0d_timeout", i), 128'(to), 128'h0);
            check($sformatf("vec%0d_lows", i), 128'(lows), 128'(vecs[i].exp_lows));
            check($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rd);
        end

        // Held read: one busy pulse over 30 cycles, then a fresh access after a drop
        @(negedge clk);
        rd[0] = 1'b1; addr[0] = 32'h0000_0040;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (!ready[0]) lows++;
        end
        check("held_single_pulse", 128'(lows), 128'h5);
        check("held_rdata", rdata[0], C_PAT);
        rd[0] = 1'b0;
        access(0, 1'b1, 1'b0, 32'h0000_0080, 128'h0, lows, got, to);
        check("held_rearm_lows", 128'(lows), 128'h5);
        check("held_rearm_rdata", got, 128'h1);

        // Reset in the 3rd busy cycle of a write must abort it
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'h0000_0100; wdata[0] = 128'hFFFF;
        repeat (3) @(negedge clk);
        check("rst_mid_busy", 128'(ready[0]), 128'h0);
        reset = 1'b1;
        wr[0] = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 128'(ready[0]), 128'h1);
        check("rst_mid_rdata", rdata[0], 128'h0);
        reset = 1'b0;
        @(negedge clk);
        access(0, 1'b1, 1'b0, 32'h0000_0100, 128'h0, lows, got, to);
        check("rst_mid_lows", 128'(lows), 128'h5);
        check("rst_mid_old_data", got, 128'h5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
